fetch_pc_queue: RTL and testbench

Parametrised fetch stage that generates sequential PCs and buffers them in a DEPTH-entry queue ahead of decode. It replaces the single-entry fetch register and fixed 4-way branch mux with a prioritised N-source redirect, a decoupling buffer, and the existing valid/allowin handshake toward the next stage. It sits at the head of the pipeline and has no upstream valid; the PC generator is the producer.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_redirect_sel.sv | 30 +++
 rtl/fetch_pc_queue.sv | 112 +++++++++++
 tb/tb_fetch_pc_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage defaults and redirect source indices
package fetch_pkg;

  // Defaults for the PC generator.
  localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;
  localparam int          FETCH_PC_STEP  = 4;

  // Redirect source channels; a lower index wins when several fire together.
  localparam int REDIR_EXC     = 0;
  localparam int REDIR_INDEX   = 1;
  localparam int REDIR_REG     = 2;
  localparam int REDIR_IMM     = 3;
  localparam int NUM_REDIR_SRC = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - combinational priority select over redirect sources
//
// Ports:
//   redirect_valid  per-source request, bit 0 highest priority
//   redirect_pc     per-source target, source i at [i*PC_W +: PC_W]
//   redir_any       any source requesting
//   redir_pc        target of the lowest-index requesting source
module pc_redirect_sel #(
  parameter int NUM_SRC = 4,
  parameter int PC_W    = 32
) (
  input  logic [NUM_SRC-1:0]      redirect_valid,
  input  logic [NUM_SRC*PC_W-1:0] redirect_pc,
  output logic                    redir_any,
  output logic [PC_W-1:0]         redir_pc
);

  // Walk from the lowest priority upward so the last hit is the winner.
  always_comb begin
    redir_any = 1'b0;
    redir_pc  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        redir_any = 1'b1;
        redir_pc  = redirect_pc[i*PC_W +: PC_W];
      end
    end
  end

endmodule

// File: rtl/fetch_pc_queue.sv
// rtl/fetch_pc_queue.sv - sequential PC generator feeding a DEPTH-entry fetch queue
//
// Ports:
//   clk, resetn      clock and asynchronous active-low reset
//   cur_stall        stops new PC generation; the queue still drains
//   redirect_valid   per-source redirect request (bit 0 highest priority)
//   redirect_pc      per-source redirect target
//   post_allowin     next stage accepts the head entry
//   goon_valid, pc   head entry toward the next stage
//   count, full      queue occupancy
module fetch_pc_queue
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter int              NUM_SRC  = NUM_REDIR_SRC,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC),
  parameter int              PC_STEP  = FETCH_PC_STEP
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cur_stall,
  input  logic [NUM_SRC-1:0]         redirect_valid,
  input  logic [NUM_SRC*PC_W-1:0]    redirect_pc,
  input  logic                       post_allowin,
  output logic                       goon_valid,
  output logic [PC_W-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              redir_any;
  logic [PC_W-1:0]   redir_pc;
  logic              push;
  logic              pop;

  logic [PC_W-1:0]   gen_pc_q, gen_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PC_W-1:0]   entry_q [DEPTH];
  logic [PC_W-1:0]   entry_d [DEPTH];

  pc_redirect_sel #(
    .NUM_SRC (NUM_SRC),
    .PC_W    (PC_W)
  ) u_sel (
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redir_any      (redir_any),
    .redir_pc       (redir_pc)
  );

  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign pc         = entry_q[head_q];
  // A redirect kills the head in the same cycle, so no handshake completes.
  assign goon_valid = (count_q != '0) && !redir_any;
  assign pop        = goon_valid && post_allowin;
  // When full, a same-cycle pop frees the slot the push is about to use.
  assign push       = !redir_any && !cur_stall && (!full || pop);

  always_comb begin
    gen_pc_d = gen_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    entry_d  = entry_q;
    if (redir_any) begin
      gen_pc_d = redir_pc;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        entry_d[tail_q] = gen_pc_q;
        tail_d          = tail_q + PTR_W'(1);
        gen_pc_d        = gen_pc_q + PC_W'(PC_STEP);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      gen_pc_q <= gen_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      entry_q  <= entry_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// tb/tb_fetch_pc_queue.sv - self-checking bench for fetch_pc_queue
module tb_fetch_pc_queue;
  import fetch_pkg::*;

  localparam int PC_W    = 32;
  localparam int DEPTH   = 4;
  localparam int NUM_SRC = 4;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    cur_stall;
  logic [NUM_SRC-1:0]      redirect_valid;
  logic [NUM_SRC*PC_W-1:0] redirect_pc;
  logic                    post_allowin;
  logic                    goon_valid;
  logic [PC_W-1:0]         pc;
  logic [2:0]              count;
  logic                    full;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue contents in order, plus the next PC to generate.
  logic [31:0] mq[$];
  logic [31:0] mgen;

  always #5 clk = ~clk;

  fetch_pc_queue #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .NUM_SRC  (NUM_SRC),
    .RESET_PC (32'hBFC0_0000),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cur_stall      (cur_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .post_allowin   (post_allowin),
    .goon_valid     (goon_valid),
    .pc             (pc),
    .count          (count),
    .full           (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    bit live;
    live = (mq.size() != 0) && (redirect_valid == '0);
    chk({tag, ":goon_valid"}, 32'(goon_valid), 32'(live));
    chk({tag, ":count"}, 32'(count), 32'(mq.size()));
    chk({tag, ":full"}, 32'(full), 32'(mq.size() == DEPTH));
    if (mq.size() != 0) chk({tag, ":pc"}, pc, mq[0]);
  endtask

  task automatic model_edge();
    int  k;
    bit  do_pop;
    bit  do_push;
    if (redirect_valid != '0) begin
      k = 0;
      while (!redirect_valid[k]) k++;
      mq.delete();
      mgen = redirect_pc[k*PC_W +: PC_W];
    end else begin
      do_pop  = (mq.size() != 0) && post_allowin;
      do_push = !cur_stall && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(mgen);
        mgen = mgen + 32'd4;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_state(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    cur_stall      = 1'b0;
    redirect_valid = '0;
    redirect_pc    = '0;
    post_allowin   = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst:goon_valid", 32'(goon_valid), 32'd0);
    chk("rst:count", 32'(count), 32'd0);
    chk("rst:full", 32'(full), 32'd0);
    chk("rst:pc", pc, 32'd0);
    resetn = 1'b1;
    mq.delete();
    mgen = 32'hBFC0_0000;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();

    // Free-running fetch with the next stage always accepting.
    do_reset();
    post_allowin = 1'b1;
    chk("p1:gv_at_release", 32'(goon_valid), 32'd0);
    cycle("p1");
    chk("p1:gv_rise", 32'(goon_valid), 32'd1);
    chk("p1:first_pc", pc, 32'hBFC0_0000);
    cycle("p1");
    chk("p1:second_pc", pc, 32'hBFC0_0004);
    repeat (8) cycle("p1");

    // Back-pressure to full, then steady full-rate through several wraps.
    do_reset();
    repeat (6) cycle("p2_fill");
    chk("p2:full", 32'(full), 32'd1);
    chk("p2:count", 32'(count), 32'd4);
    chk("p2:head", pc, 32'hBFC0_0000);
    post_allowin = 1'b1;
    repeat (16) cycle("p2_wrap");
    chk("p2:count_after_wraps", 32'(count), 32'd4);
    chk("p2:pc_after_wraps", pc, 32'hBFC0_0040);
    cur_stall = 1'b1;
    repeat (5) cycle("p2_drain");
    cur_stall = 1'b0;
    repeat (3) cycle("p2_resume");

    // Two redirect sources at once; the lower index wins.
    do_reset();
    repeat (3) cycle("p3_fill");
    chk("p3:count3", 32'(count), 32'd3);
    post_allowin = 1'b1;
    redirect_valid = 4'b1010;
    redirect_pc[REDIR_INDEX*PC_W +: PC_W] = 32'h8000_0100;
    redirect_pc[REDIR_IMM*PC_W +: PC_W]   = 32'h8000_0200;
    #1;
    chk("p3:gv_killed", 32'(goon_valid), 32'd0);
    cycle("p3_redir");
    redirect_valid = '0;
    #1;
    chk("p3:count_cleared", 32'(count), 32'd0);
    cycle("p3_after");
    chk("p3:pc_target", pc, 32'h8000_0100);
    cycle("p3_after");
    chk("p3:pc_target_next", pc, 32'h8000_0104);

    // PC wraps through zero.
    post_allowin = 1'b0;
    redirect_valid = 4'b0001;
    redirect_pc[REDIR_EXC*PC_W +: PC_W] = 32'hFFFF_FFFC;
    cycle("p4_redir");
    redirect_valid = '0;
    repeat (3) cycle("p4_fill");
    post_allowin = 1'b1;
    chk("p4:pc0", pc, 32'hFFFF_FFFC);
    cycle("p4_drain");
    chk("p4:pc1", pc, 32'h0000_0000);
    cycle("p4_drain");
    chk("p4:pc2", pc, 32'h0000_0004);

    // Asynchronous reset mid-drain.
    do_reset();
    repeat (3) cycle("p5_fill");
    post_allowin = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("p5:async_gv", 32'(goon_valid), 32'd0);
    chk("p5:async_count", 32'(count), 32'd0);
    mq.delete();
    mgen = 32'hBFC0_0000;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle("p5_restart");
    chk("p5:restart_pc", pc, 32'hBFC0_0000);
    repeat (3) cycle("p5_run");

    // Stall drains the queue while the generator holds.
    do_reset();
    repeat (3) cycle("p6_fill");
    post_allowin = 1'b1;
    cur_stall = 1'b1;
    repeat (3) cycle("p6_stall");
    chk("p6:drained", 32'(count), 32'd0);
    cur_stall = 1'b0;
    cycle("p6_release");
    chk("p6:resume_pc", pc, 32'hBFC0_000C);
    repeat (2) cycle("p6_run");

    // Randomized traffic against the model.
    do_reset();
    repeat (400) begin
      post_allowin   = ($urandom_range(0, 3) != 0);
      cur_stall      = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      for (int s = 0; s < NUM_SRC; s++) redirect_pc[s*PC_W +: PC_W] = $urandom;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
